fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator that produces the fetch_data_t stream consumed by the IF/ID pipeline register.
- Owns the PC and issues one request at a time on the instruction bus (valid/addr held until data_ok).
- Presents each fetched instruction with its PC to the decode stage.
- Absorbs downstream stalls and branch/jump redirects, including redirects that arrive while a bus request is outstanding.

Parameters:
PC_INIT, 64'h0000_0000_8000_0000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  instruction bus request valid
ireq_addr  out  64  instruction bus request address
iresp_data_ok  in  1  bus response strobe; completes the current request
iresp_data  in  32  instruction word, valid with iresp_data_ok
stall  in  1  downstream cannot accept (OR of all pipeline stall sources)
redirect  in  1  jump/branch taken; refetch from redirect_pc
redirect_pc  in  64  redirect target
out_valid  out  1  out_instr/out_pc hold a real instruction
out_pc  out  64  PC of presented instruction (dataF.pc)
out_instr  out  32  presented instruction (dataF.raw_instr); 0 when out_valid=0
busy  out  1  fetch waiting on memory; used by the pipeline as stallI

Behaviour:
- Architectural state: pc (64), instr_q (32), state {FETCH, HOLD}, redir_pend (1), redir_pc (64).
- Reset (synchronous): pc=PC_INIT, state=FETCH, redir_pend=0, instr_q=0.
- Outputs while reset is asserted: ireq_valid=0, out_valid=0, out_instr=0, busy=0.
- All outputs are combinational from registers only; there are no input-to-output paths.
  - ireq_valid = (state==FETCH) and not reset.
  - ireq_addr = pc.
  - busy = ireq_valid.
  - out_valid = (state==HOLD).
  - out_pc = pc.
  - out_instr = instr_q when HOLD, else 0.
- Bus rule: while ireq_valid=1, ireq_addr is held constant until the cycle iresp_data_ok=1. A new address may appear the following cycle.
- FETCH state:
  - data_ok=0, redirect=1: redir_pend<=1, redir_pc<=redirect_pc (latest redirect wins); stay in FETCH.
  - data_ok=1 and (redir_pend or redirect): discard iresp_data. pc<=redirect_pc if redirect=1, else redir_pc. redir_pend<=0. Stay in FETCH; the new request is issued next cycle.
  - data_ok=1, no redirect pending: instr_q<=iresp_data, state<=HOLD.
- HOLD state:
  - redirect=1 (takes priority over stall): drop instr_q, pc<=redirect_pc, state<=FETCH.
  - stall=0: instruction is accepted this cycle. pc<=pc+PC_STEP (64-bit wrap), state<=FETCH.
  - stall=1: hold all state; out_* remain stable.
- Latency: request is asserted the cycle after entering FETCH. out_valid rises the cycle after data_ok. Throughput is at most one instruction per 2 cycles with zero-wait memory.
- PC alignment is not checked here; misaligned redirect targets are fetched as given.
- Reset mid-request: the outstanding request is abandoned and any in-flight data_ok is ignored by the reset. The first post-reset request is to PC_INIT.
- When redirect and data_ok coincide in FETCH with redir_pend=1, the incoming redirect_pc wins over redir_pc.

Test Plan:
- Reset release, memory returns data_ok 1 cycle after each request with instr 0x00000013 → ireq_addr 0x80000000, then 0x80000004, 0x80000008. out_valid pulses each 2 cycles with matching out_pc.
- Memory delays data_ok 3 cycles → ireq_valid=1 and ireq_addr=0x80000000 held stable for all 3 cycles; busy=1 throughout; out_valid=0, out_instr=0.
- In HOLD (out_pc=0x80000004), stall=1 for 4 cycles → out_pc/out_instr constant and no new request. On stall=0, next ireq_addr=0x80000008.
- Redirect to 0x80000100 during a WAIT with data_ok 2 cycles later → returned word discarded, out_valid stays 0. Next ireq_addr=0x80000100.
- Redirect to 0x80000200 while in HOLD with stall=1 → out_valid drops next cycle. Next ireq_addr=0x80000200, not pc+4.
- Two redirects (0x80000300 then 0x80000400) before data_ok, then reset asserted one cycle during a pending request → after the redirects the fetch goes to 0x80000400. After reset, ireq_addr=0x80000000 and redir_pend is cleared.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-outstanding instruction fetch initiator feeding IF/ID
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000,
  parameter int          PC_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        busy
);

  localparam logic [63:0] c_PC_STEP = 64'(PC_STEP);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [63:0] r_pc,     w_pc_nxt;
  logic [31:0] r_instr_q, w_instr_nxt;
  logic        r_redir_pend, w_pend_nxt;
  logic [63:0] r_redir_pc,   w_rpc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= PC_INIT;
      r_instr_q    <= 32'd0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 64'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr_q    <= w_instr_nxt;
      r_redir_pend <= w_pend_nxt;
      r_redir_pc   <= w_rpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr_q;
    w_pend_nxt  = r_redir_pend;
    w_rpc_nxt   = r_redir_pc;
    case (r_state)
      S_FETCH: begin
        if (iresp_data_ok) begin
          // A redirect seen during the request makes the returned word stale.
          if (redirect || r_redir_pend) begin
            w_pc_nxt   = redirect ? redirect_pc : r_redir_pc;
            w_pend_nxt = 1'b0;
          end else begin
            w_instr_nxt = iresp_data;
            w_state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          // The address must stay put on the bus, so park the target.
          w_pend_nxt = 1'b1;
          w_rpc_nxt  = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_instr_nxt = 32'd0;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_pc_nxt    = r_pc + c_PC_STEP;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign ireq_valid = (r_state == S_FETCH) && !reset;
  assign ireq_addr  = r_pc;
  assign busy       = ireq_valid;
  assign out_valid  = (r_state == S_HOLD) && !reset;
  assign out_pc     = r_pc;
  assign out_instr  = out_valid ? r_instr_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed table-driven bench for fetch_unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        busy;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dok;
    logic [31:0] data;
    logic        stl;
    logic        rdr;
    logic [63:0] rpc;
    logic        e_iv;
    logic [63:0] e_pc;
    logic        e_ov;
    logic [31:0] e_oi;
  } vec_t;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  vec_t tbl[32];
  int   n_vec;
  int   n_bad;
  int   n_tbl;

  function automatic vec_t mk(logic dok, logic [31:0] data, logic stl, logic rdr,
                              logic [63:0] rpc, logic e_iv, logic [63:0] e_pc,
                              logic e_ov, logic [31:0] e_oi);
    vec_t v;
    v.dok = dok; v.data = data; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_ov = e_ov; v.e_oi = e_oi;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_tbl] = v;
    n_tbl++;
  endtask

  task automatic check(input string name, input logic e_iv, input logic [63:0] e_pc,
                       input logic e_ov, input logic [31:0] e_oi);
    n_vec++;
    if (ireq_valid !== e_iv || busy !== e_iv || ireq_addr !== e_pc || out_pc !== e_pc ||
        out_valid !== e_ov || out_instr !== e_oi) begin
      n_bad++;
      $display("FAIL %s: got iv=%0b busy=%0b addr=%h opc=%h ov=%0b oi=%h, want iv=%0b busy=%0b addr=%h opc=%h ov=%0b oi=%h",
               name, ireq_valid, busy, ireq_addr, out_pc, out_valid, out_instr,
               e_iv, e_iv, e_pc, e_pc, e_ov, e_oi);
    end
  endtask

  task automatic drive(input logic dok, input logic [31:0] data, input logic stl,
                       input logic rdr, input logic [63:0] rpc);
    iresp_data_ok = dok;
    iresp_data    = data;
    stall         = stl;
    redirect      = rdr;
    redirect_pc   = rpc;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_tbl = 0;
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);

    //   dok data          stl rdr rpc                      | iv pc                       ov oi
    add(mk(0, 32'h0,        0, 0, 64'h0,                      1, B,                       0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      1, B,                       0, 32'h0));
    add(mk(1, 32'h00000013, 0, 0, 64'h0,                      1, B,                       0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, B,                       1, 32'h00000013));
    add(mk(1, 32'h00a00093, 0, 0, 64'h0,                      1, B + 4,                   0, 32'h0));
    add(mk(0, 32'h0,        1, 0, 64'h0,                      0, B + 4,                   1, 32'h00a00093));
    add(mk(0, 32'h0,        1, 0, 64'h0,                      0, B + 4,                   1, 32'h00a00093));
    add(mk(0, 32'h0,        1, 0, 64'h0,                      0, B + 4,                   1, 32'h00a00093));
    add(mk(0, 32'h0,        1, 0, 64'h0,                      0, B + 4,                   1, 32'h00a00093));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, B + 4,                   1, 32'h00a00093));
    add(mk(1, 32'h00b00093, 0, 0, 64'h0,                      1, B + 8,                   0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, B + 8,                   1, 32'h00b00093));
    add(mk(0, 32'h0,        0, 1, B + 64'h100,                1, B + 12,                  0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      1, B + 12,                  0, 32'h0));
    add(mk(1, 32'hdead0000, 0, 0, 64'h0,                      1, B + 12,                  0, 32'h0));
    add(mk(1, 32'h00c00093, 0, 0, 64'h0,                      1, B + 64'h100,             0, 32'h0));
    add(mk(0, 32'h0,        1, 1, B + 64'h200,                0, B + 64'h100,             1, 32'h00c00093));
    add(mk(0, 32'h0,        0, 1, B + 64'h300,                1, B + 64'h200,             0, 32'h0));
    add(mk(0, 32'h0,        0, 1, B + 64'h400,                1, B + 64'h200,             0, 32'h0));
    add(mk(1, 32'hbad00000, 0, 0, 64'h0,                      1, B + 64'h200,             0, 32'h0));
    add(mk(1, 32'h00d00093, 0, 0, 64'h0,                      1, B + 64'h400,             0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, B + 64'h400,             1, 32'h00d00093));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      1, B + 64'h404,             0, 32'h0));
    add(mk(0, 32'h0,        0, 1, B + 64'h500,                1, B + 64'h404,             0, 32'h0));
    add(mk(1, 32'hbad11111, 0, 1, B + 64'h600,                1, B + 64'h404,             0, 32'h0));
    add(mk(1, 32'h00e00093, 0, 0, 64'h0,                      1, B + 64'h600,             0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, B + 64'h600,             1, 32'h00e00093));
    add(mk(1, 32'h00000001, 0, 0, 64'h0,                      1, B + 64'h604,             0, 32'h0));
    add(mk(0, 32'h0,        0, 1, 64'hffff_ffff_ffff_fffc,   0, B + 64'h604,             1, 32'h00000001));
    add(mk(1, 32'h00000002, 0, 0, 64'h0,                      1, 64'hffff_ffff_ffff_fffc, 0, 32'h0));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      0, 64'hffff_ffff_ffff_fffc, 1, 32'h00000002));
    add(mk(0, 32'h0,        0, 0, 64'h0,                      1, 64'h0,                   0, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ireq_valid !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outs: got iv=%0b busy=%0b ov=%0b oi=%h, want all 0",
               ireq_valid, busy, out_valid, out_instr);
    end
    reset = 1'b0;
    #1;

    for (int i = 0; i < n_tbl; i++) begin
      check($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_pc, tbl[i].e_ov, tbl[i].e_oi);
      drive(tbl[i].dok, tbl[i].data, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
      @(posedge clk);
      #1;
    end

    // Reset lands on a request that also has a redirect parked.
    check("rst_seq0", 1'b1, 64'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, B + 64'h700);
    @(posedge clk);
    #1;
    check("rst_seq1", 1'b1, 64'h0, 1'b0, 32'h0);
    reset = 1'b1;
    drive(1'b1, 32'hbad22222, 1'b0, 1'b0, 64'h0);
    #1;
    n_vec++;
    if (ireq_valid !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got iv=%0b busy=%0b ov=%0b oi=%h, want all 0",
               ireq_valid, busy, out_valid, out_instr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    #1;
    check("rst_seq2", 1'b1, B, 1'b0, 32'h0);
    drive(1'b1, 32'h00f00093, 1'b0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    check("rst_seq3", 1'b0, B, 1'b1, 32'h00f00093);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    check("rst_seq4", 1'b1, B + 4, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
